// File: rtl/burst_rd_responder_if.sv
// rtl/burst_rd_responder_if.sv - burst read request/response channel between cache and responder
interface burst_rd_responder_if;
  logic        mem_rd_req_valid;
  logic [31:0] mem_rd_req_addr;
  logic        mem_rd_req_ready;
  logic        mem_rd_rsp_valid;
  logic [31:0] mem_rd_rsp_data;
  logic        mem_rd_rsp_last;
  logic        mem_rd_rsp_ready;

  modport master (
    output mem_rd_req_valid,
    output mem_rd_req_addr,
    input  mem_rd_req_ready,
    input  mem_rd_rsp_valid,
    input  mem_rd_rsp_data,
    input  mem_rd_rsp_last,
    output mem_rd_rsp_ready
  );

  modport slave (
    input  mem_rd_req_valid,
    input  mem_rd_req_addr,
    output mem_rd_req_ready,
    output mem_rd_rsp_valid,
    output mem_rd_rsp_data,
    output mem_rd_rsp_last,
    input  mem_rd_rsp_ready
  );
endinterface

// File: rtl/burst_rd_responder.sv
// rtl/burst_rd_responder.sv - aligned burst read responder with 2-deep prefetch buffer in front of a word RAM
module burst_rd_responder #(
  parameter int BURST_LEN = 8,
  parameter int RAM_AW    = 16,
  parameter int LATENCY   = 0
) (
  input  logic                clk,
  input  logic                rst,
  burst_rd_responder_if.slave bus,
  output logic                ram_ren,
  output logic [RAM_AW-1:0]   ram_raddr,
  input  logic [31:0]         ram_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam int              CW        = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]   LEN       = CW'(BURST_LEN);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [RAM_AW-1:0] OFF_MASK = RAM_AW'(BURST_LEN - 1);
  localparam logic [7:0]      DLY_INIT  = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  logic [1:0]        r_state;
  logic [RAM_AW-1:0] r_base;
  logic [CW-1:0]     r_issue_cnt;
  logic [CW-1:0]     r_beat_cnt;
  logic [7:0]        r_dly_cnt;
  logic              r_inflight;
  logic [31:0]       r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_accept;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [RAM_AW-1:0] w_req_base;
  logic [31:0]       w_head;
  logic              w_unused;

  assign w_unused   = ^{bus.mem_rd_req_addr[31:RAM_AW+2], bus.mem_rd_req_addr[1:0]};
  assign w_req_base = bus.mem_rd_req_addr[RAM_AW+1:2] & ~OFF_MASK;

  assign bus.mem_rd_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = bus.mem_rd_req_valid && bus.mem_rd_req_ready;

  // The word returning from RAM this cycle counts as buffered and is presented
  // straight through when nothing older is queued.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_valid = (w_occ != 3'd0) && !rst;
  assign w_pop   = w_valid && bus.mem_rd_rsp_ready;
  assign w_head  = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : (r_inflight ? ram_rdata : 32'd0);

  assign w_issue = (r_state == S_BURST) && (r_issue_cnt < LEN) &&
                   ((w_occ - {2'b00, w_pop}) < 3'd2);

  assign ram_ren   = w_issue;
  assign ram_raddr = r_base + RAM_AW'(r_issue_cnt);

  assign bus.mem_rd_rsp_valid = w_valid;
  assign bus.mem_rd_rsp_data  = w_head;
  assign bus.mem_rd_rsp_last  = (r_beat_cnt == LAST_BEAT) && w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base      <= w_req_base;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_dly_cnt   <= DLY_INIT;
            r_state     <= (LATENCY > 0) ? S_DELAY : S_BURST;
          end
        end
        S_DELAY: begin
          if (r_dly_cnt == 8'd0) r_state <= S_BURST;
          else                   r_dly_cnt <= r_dly_cnt - 8'd1;
        end
        S_BURST: begin
          if (w_pop && (r_beat_cnt == LAST_BEAT)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (w_pop)   r_beat_cnt  <= r_beat_cnt + 1'b1;
      r_inflight <= w_issue;

      // Always capture the returning word; if it was popped through the bypass
      // the read pointer advances past it in the same edge.
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= ram_rdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_burst_rd_responder.sv
// tb/tb_burst_rd_responder.sv - directed self-checking bench for burst_rd_responder
module tb_burst_rd_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_rd_responder_if bus0();
  burst_rd_responder_if bus5();

  logic        ren0, ren5;
  logic [15:0] raddr0, raddr5;
  logic [31:0] rdata0, rdata5;

  always @(posedge clk) if (ren0) rdata0 <= 32'h1000_0000 + {16'h0, raddr0};
  always @(posedge clk) if (ren5) rdata5 <= 32'h1000_0000 + {16'h0, raddr5};

  burst_rd_responder #(.BURST_LEN(8), .RAM_AW(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .ram_ren(ren0), .ram_raddr(raddr0), .ram_rdata(rdata0)
  );

  burst_rd_responder #(.BURST_LEN(8), .RAM_AW(16), .LATENCY(5)) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5),
    .ram_ren(ren5), .ram_raddr(raddr5), .ram_rdata(rdata5)
  );

  localparam logic [5:0] PAT = 6'b101001;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready held high; mode 1: ready follows PAT. abort_after>0 returns after that many beats.
  task automatic do_burst(input logic [31:0] addr, input int mode, input logic [15:0] exp_word,
                          input int abort_after);
    int k, c, first_v, last_c, issued, popped, ridx;
    logic pv, pr, pl, pop, ok;
    logic [31:0] pd;
    @(negedge clk);
    bus0.mem_rd_req_valid = 1'b1;
    bus0.mem_rd_req_addr  = addr;
    bus0.mem_rd_rsp_ready = 1'b1;
    #1;
    check("req_ready_idle", bus0.mem_rd_req_ready, 1);
    check("ren_idle", ren0, 0);
    k = 0; c = 0; first_v = -1; last_c = -1; issued = 0; popped = 0; ridx = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (k < 8 && c < 60) begin
      @(negedge clk);
      c++;
      bus0.mem_rd_req_valid = 1'b0;
      bus0.mem_rd_rsp_ready = (mode == 0) ? 1'b1 : PAT[ridx % 6];
      ridx++;
      #1;
      check("req_ready_busy", bus0.mem_rd_req_ready, 0);
      if (pv && !pr) begin
        check("stall_valid", bus0.mem_rd_rsp_valid, 1);
        check("stall_data", bus0.mem_rd_rsp_data, pd);
        check("stall_last", bus0.mem_rd_rsp_last, pl);
      end
      pop = bus0.mem_rd_rsp_valid && bus0.mem_rd_rsp_ready;
      if (ren0) begin
        ok = (issued - popped - int'(pop)) <= 1;
        check("credit", ok, 1);
      end
      if (bus0.mem_rd_rsp_valid && first_v < 0) first_v = c;
      if (pop) begin
        check("beat_data", bus0.mem_rd_rsp_data, 32'h1000_0000 + {16'h0, exp_word} + k);
        check("beat_last", bus0.mem_rd_rsp_last, (k == 7) ? 1 : 0);
        k++;
        last_c = c;
      end
      if (ren0) issued++;
      if (pop)  popped++;
      pv = bus0.mem_rd_rsp_valid;
      pr = bus0.mem_rd_rsp_ready;
      pd = bus0.mem_rd_rsp_data;
      pl = bus0.mem_rd_rsp_last;
      if (abort_after != 0 && k == abort_after) return;
    end
    bus0.mem_rd_rsp_ready = 1'b1;
    check("beat_count", k, 8);
    if (mode == 0) begin
      check("first_valid_cycle", first_v, 2);
      check("last_beat_cycle", last_c, 9);
    end
    @(negedge clk);
    #1;
    check("req_ready_after", bus0.mem_rd_req_ready, 1);
    check("valid_after", bus0.mem_rd_rsp_valid, 0);
  endtask

  initial begin
    int fr, fv, k, c, acc, l0, l1, last_bc;
    int acc_c [2];
    logic [31:0] expd;

    rst = 1'b1;
    bus0.mem_rd_req_valid = 1'b0; bus0.mem_rd_req_addr = '0; bus0.mem_rd_rsp_ready = 1'b1;
    bus5.mem_rd_req_valid = 1'b0; bus5.mem_rd_req_addr = '0; bus5.mem_rd_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", bus0.mem_rd_req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", bus0.mem_rd_req_ready, 1);
    check("post_rst_valid", bus0.mem_rd_rsp_valid, 0);
    check("post_rst_last", bus0.mem_rd_rsp_last, 0);
    check("post_rst_ren", ren0, 0);
    check("post_rst_data", bus0.mem_rd_rsp_data, 0);
    check("post_rst_req_ready_l5", bus5.mem_rd_req_ready, 1);

    do_burst(32'h0000_0040, 0, 16'h0010, 0);
    do_burst(32'h0000_0040, 1, 16'h0010, 0);
    do_burst(32'h0000_005C, 0, 16'h0010, 0);

    // LATENCY=5 instance
    @(negedge clk);
    bus5.mem_rd_req_valid = 1'b1;
    bus5.mem_rd_req_addr  = 32'h0000_0040;
    #1;
    check("l5_req_ready_idle", bus5.mem_rd_req_ready, 1);
    fr = -1; fv = -1; k = 0; c = 0;
    while (k < 8 && c < 40) begin
      @(negedge clk);
      c++;
      bus5.mem_rd_req_valid = 1'b0;
      #1;
      check("l5_req_ready_busy", bus5.mem_rd_req_ready, 0);
      if (ren5 && fr < 0) fr = c;
      if (bus5.mem_rd_rsp_valid && fv < 0) fv = c;
      if (bus5.mem_rd_rsp_valid) begin
        check("l5_data", bus5.mem_rd_rsp_data, 32'h1000_0010 + k);
        k++;
      end
    end
    check("l5_first_ren", fr, 6);
    check("l5_first_valid", fv, 7);
    check("l5_beats", k, 8);
    @(negedge clk);
    #1;
    check("l5_req_ready_after", bus5.mem_rd_req_ready, 1);

    // Mid-burst reset after the third accepted beat
    do_burst(32'h0000_0040, 0, 16'h0010, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", bus0.mem_rd_req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("midrst_valid", bus0.mem_rd_rsp_valid, 0);
      check("midrst_last", bus0.mem_rd_rsp_last, 0);
      check("midrst_ren", ren0, 0);
      @(negedge clk);
    end
    do_burst(32'h0000_0080, 0, 16'h0020, 0);

    // Back-to-back requests with the second held valid
    @(negedge clk);
    bus0.mem_rd_req_valid = 1'b1;
    bus0.mem_rd_req_addr  = 32'h0000_0000;
    bus0.mem_rd_rsp_ready = 1'b1;
    c = 0; acc = 0; k = 0; l0 = 0; l1 = 0; last_bc = -1;
    acc_c[0] = -1; acc_c[1] = -1;
    while (k < 16 && c < 40) begin
      #1;
      if (bus0.mem_rd_req_valid && bus0.mem_rd_req_ready) begin
        if (acc < 2) acc_c[acc] = c;
        acc++;
      end
      if (bus0.mem_rd_rsp_valid && bus0.mem_rd_rsp_ready) begin
        expd = (k < 8) ? 32'h1000_0000 + k : 32'h1000_0038 + (k - 8);
        check("b2b_data", bus0.mem_rd_rsp_data, expd);
        if (bus0.mem_rd_rsp_last) begin
          if (k < 8) l0++;
          else       l1++;
        end
        if (k == 7) last_bc = c;
        k++;
      end
      @(negedge clk);
      c++;
      if (acc == 1) bus0.mem_rd_req_addr = 32'h0000_00E0;
      if (acc >= 2) bus0.mem_rd_req_valid = 1'b0;
    end
    check("b2b_beats", k, 16);
    check("b2b_accepts", acc, 2);
    check("b2b_second_accept", acc_c[1], last_bc + 1);
    check("b2b_last_first", l0, 1);
    check("b2b_last_second", l1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
